// File: rtl/norm_sqrt_if.sv
// norm_sqrt handshake bundle: squared-norm request in, rounded/floor root out.
// master drives the request and out_ready; slave is the sqrt stage.
interface norm_sqrt_if #(
   parameter int PRECIS   = 39,
   parameter int LEN_SIZE = 8,
   parameter int ROOT_W   = (PRECIS + 1) / 2
);
   logic                start;
   logic [PRECIS-1:0]   norm2;
   logic [LEN_SIZE-1:0] len;
   logic                busy;
   logic                out_valid;
   logic                out_ready;
   logic [ROOT_W-1:0]   norm;
   logic [LEN_SIZE-1:0] len_out;
   logic                exact;

   modport master (
      output start, norm2, len, out_ready,
      input  busy, out_valid, norm, len_out, exact
   );

   modport slave (
      input  start, norm2, len, out_ready,
      output busy, out_valid, norm, len_out, exact
   );
endinterface

// File: rtl/norm_sqrt.sv
// Non-restoring integer square root, one root bit per clock.
// Define NORM_SQRT_ROUND_EN to round the root to nearest instead of floor.
module norm_sqrt #(
   parameter int PRECIS   = 39,
   parameter int LEN_SIZE = 8,
   parameter int ROOT_W   = (PRECIS + 1) / 2
) (
   input logic       clk,
   input logic       rst,
   norm_sqrt_if.slave bus
);
   localparam int RAD_W = 2 * ROOT_W;
   localparam int REM_W = ROOT_W + 2;
   localparam int IW    = $clog2(ROOT_W);

`ifdef NORM_SQRT_ROUND_EN
   typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

   state_t state, nxt;

   logic [RAD_W-1:0]    rad;
   logic [REM_W-1:0]    rem;
   logic [ROOT_W-1:0]   root;
   logic [IW-1:0]       iter;
   logic [ROOT_W-1:0]   norm;
   logic [LEN_SIZE-1:0] len_out;
   logic                exact;

   logic [IW:0]         idx;
   logic [1:0]          pair;
   logic [REM_W-1:0]    rem_sh, rem_n, rem_f;
   logic [ROOT_W-1:0]   root_n;
   logic                last;

   assign idx  = {iter, 1'b0};
   assign pair = rad[idx +: 2];
   assign last = (iter == '0);

   // remainder is two's complement; its sign picks subtract vs add
   assign rem_sh = (rem << 2) | {{ROOT_W{1'b0}}, pair};
   assign rem_n  = rem[REM_W-1] ? rem_sh + {root, 2'b11}
                                : rem_sh - {root, 2'b01};
   assign root_n = {root[ROOT_W-2:0], ~rem_n[REM_W-1]};
   assign rem_f  = rem_n[REM_W-1] ? rem_n + {1'b0, root_n, 1'b1}
                                  : rem_n;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (bus.start) nxt = (bus.len == '0) ? DONE : CALC;
         CALC: if (last) begin
`ifdef NORM_SQRT_ROUND_EN
            nxt = ROUND;
`else
            nxt = DONE;
`endif
         end
`ifdef NORM_SQRT_ROUND_EN
         ROUND: nxt = DONE;
`endif
         DONE: if (bus.out_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rad     <= '0;
         rem     <= '0;
         root    <= '0;
         iter    <= '0;
         norm    <= '0;
         len_out <= '0;
         exact   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (bus.start) begin
               rad     <= RAD_W'(bus.norm2);
               len_out <= bus.len;
               if (bus.len == '0) begin
                  norm  <= '0;
                  exact <= 1'b1;
               end else begin
                  root <= '0;
                  rem  <= '0;
                  iter <= IW'(ROOT_W - 1);
               end
            end
            CALC: begin
               root <= root_n;
               iter <= iter - 1'b1;
               if (last) begin
                  rem   <= rem_f;
                  exact <= (rem_f == '0);
`ifndef NORM_SQRT_ROUND_EN
                  norm  <= root_n;
`endif
               end else begin
                  rem <= rem_n;
               end
            end
`ifdef NORM_SQRT_ROUND_EN
            // sqrt >= root+0.5 exactly when remainder exceeds root
            ROUND: begin
               if (rem > {2'b00, root})
                  norm <= (&root) ? root : root + 1'b1;
               else
                  norm <= root;
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.norm      = norm;
   assign bus.len_out   = len_out;
   assign bus.exact     = exact;
endmodule

// File: tb/tb_norm_sqrt.sv
// Directed-vector bench for norm_sqrt: latency, root values, exact flag,
// len passthrough, backpressure, start collisions and mid-run reset.
module tb_norm_sqrt;
   logic clk = 1'b0;
   logic rst = 1'b1;

   norm_sqrt_if bus ();

   norm_sqrt dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef NORM_SQRT_ROUND_EN
   localparam int LAT = 22;
   localparam logic [63:0] R7 = 3;
`else
   localparam int LAT = 21;
   localparam logic [63:0] R7 = 2;
`endif

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic accept(input bit poke);
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (poke) begin
         bus.start = 1'b1;
         bus.norm2 = 39'd100;
         bus.len   = 8'd3;
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      check("drop_valid", 64'(bus.out_valid), 0);
      check("idle_busy", 64'(bus.busy), 0);
   endtask

   task automatic run(input logic [38:0] n2, input logic [7:0] l,
                      input logic [63:0] en, input logic ex,
                      input int lat, input bit poke, input bit acc);
      int cyc;
      @(negedge clk);
      bus.start = 1'b1;
      bus.norm2 = n2;
      bus.len   = l;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      cyc = 1;
      while (!bus.out_valid && cyc < 200) begin
         if (poke && cyc == 5) begin
            bus.start = 1'b1;
            bus.norm2 = 39'd49;
            bus.len   = 8'd9;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.start = 1'b0;
      check("latency", 64'(cyc), 64'(lat));
      check("norm", 64'(bus.norm), en);
      check("exact", 64'(bus.exact), 64'(ex));
      check("len_out", 64'(bus.len_out), 64'(l));
      if (acc) accept(1'b0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.norm2     = '0;
      bus.len       = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", 64'(bus.busy), 0);
      check("rst_valid", 64'(bus.out_valid), 0);
      check("rst_norm", 64'(bus.norm), 0);
      check("rst_len", 64'(bus.len_out), 0);
      check("rst_exact", 64'(bus.exact), 0);

      run(39'd1 << 30, 8'd4, 32768, 1'b1, LAT, 1'b0, 1'b1);
      run({39{1'b1}}, 8'd255, 741455, 1'b0, LAT, 1'b0, 1'b1);
      run(39'd7, 8'd1, R7, 1'b0, LAT, 1'b0, 1'b1);
      run(39'd6, 8'd2, 2, 1'b0, LAT, 1'b0, 1'b1);
      run(39'd12345, 8'd0, 0, 1'b1, 1, 1'b0, 1'b1);
      run(39'd1000000, 8'd7, 1000, 1'b1, LAT, 1'b0, 1'b1);

      // start pulse mid-CALC, then hold in DONE, then start on accept
      run(39'd7, 8'd1, R7, 1'b0, LAT, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 64'(bus.out_valid), 1);
         check("hold_norm", 64'(bus.norm), R7);
         check("hold_len", 64'(bus.len_out), 1);
      end
      accept(1'b1);
      run(39'd10, 8'd5, 3, 1'b0, LAT, 1'b0, 1'b1);

      // reset during iteration 10 of CALC
      @(negedge clk);
      bus.start = 1'b1;
      bus.norm2 = 39'd123456789;
      bus.len   = 8'd6;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mid_busy", 64'(bus.busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 64'(bus.busy), 0);
      for (int i = 0; i < LAT; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) check("abort_valid", 64'(bus.out_valid), 0);
      end
      check("abort_idle", 64'(bus.busy), 0);
      run(39'd9, 8'd2, 3, 1'b1, LAT, 1'b0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/norm_sqrt.md
Name: norm_sqrt

Overview:
Downstream stage of the vector-norm datapath. It consumes the squared-norm accumulator result (norm2, 39-bit) and element count (len, 8-bit) once the datapath signals done. It computes the integer square root with an iterative non-restoring algorithm, one result bit per clock. The result is the vector's Euclidean norm in fixed point: 30 fractional bits in norm2 give 15 fractional bits in norm.

Parameters:
PRECIS, 39, width of norm2 input.
LEN_SIZE, 8, width of len input/output.
ROOT_W, (PRECIS+1)/2 = 20, width of the norm result.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  datapath done strobe; norm2/len valid while high.
norm2  input  PRECIS  squared norm, unsigned.
len  input  LEN_SIZE  number of vector elements summed.
busy  output  1  high in any state other than IDLE.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  consumer accepts the result when high together with out_valid.
norm  output  ROOT_W  floor(sqrt(norm2)) (rounded when the optional feature is compiled in).
len_out  output  LEN_SIZE  captured len, passed through with the result.
exact  output  1  high when the remainder is 0 (norm2 is a perfect square).

Behaviour:
- Reset: state=IDLE; busy=0, out_valid=0, norm=0, len_out=0, exact=0; internal radicand, remainder, root and iteration counter cleared. Reset mid-computation aborts the computation with no output.
- States: IDLE, CALC, ROUND (present only with the optional feature), DONE.
- IDLE:
  - On start=1, capture norm2 into the radicand register and len into len_out.
  - If len==0, go directly to DONE: norm=0, exact=1, norm2 value ignored (1-edge latency).
  - Otherwise clear root/remainder, set iter=ROOT_W-1, go to CALC.
- CALC: one iteration per edge on radicand bits [2*iter+1:2*iter].
  - Remainder is (ROOT_W+2)-bit signed.
  - If the remainder is non-negative, subtract (root<<2|1); otherwise add (root<<2|3).
  - Shift the next root bit in as the inverted new remainder sign.
  - After the iter==0 iteration:
    - Correct a negative final remainder by adding (root<<1|1).
    - Go to DONE, or to ROUND when the feature is compiled in.
- Latency: out_valid rises ROOT_W+1 rising edges after the capture edge (21 with defaults); +1 with ROUND.
- DONE:
  - out_valid=1; norm, exact and len_out stable.
  - When out_ready=1, go to IDLE and drop out_valid on that edge.
  - out_ready is ignored outside DONE.
- start is ignored while busy=1, including in the cycle that DONE is accepted. A new capture occurs only in IDLE.
- Result guarantee: norm^2 <= norm2 < (norm+1)^2. For the defaults, the maximum norm is 741455, so the result always fits in ROOT_W bits.

Optional Feature:
NORM_SQRT_ROUND_EN
- Defined:
  - ROUND state inserted after CALC.
  - If the final remainder > root, norm = root+1 (round to nearest, since sqrt >= r+0.5 iff rem > r), saturating at all-ones.
  - exact still reflects remainder==0.
  - Latency is ROOT_W+2.
- Undefined: no ROUND state; norm truncates (floor); latency ROOT_W+1.

Test Plan:
- rst=1 asserted for 2 edges with out_ready=0, then released -> all outputs 0, busy=0. Then start with norm2=2^30 (1.0), len=4 -> out_valid exactly 21 edges after capture; norm=32768, exact=1, len_out=4.
- norm2=2^39-1, len=255 -> norm=741455, exact=0 (remainder 296862). Same result with ROUND enabled, since 296862 < 741455.
- norm2=7, len=1 -> norm=2, exact=0. With NORM_SQRT_ROUND_EN: norm=3 after 22 edges. norm2=6 -> norm=2 in both builds.
- len=0, norm2=12345 -> out_valid after 1 edge, norm=0, exact=1, len_out=0.
- Backpressure and collision:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable.
  - start pulses during CALC and in the accept cycle are ignored.
  - The next start in IDLE is processed normally.
- rst pulsed at iteration 10 of CALC -> next edge state IDLE, busy=0, out_valid never asserted. A following start with norm2=9 -> norm=3, exact=1.
